// File: rtl/dmem_mmio_pkg.sv
// -----------------------------------------------------------------------------
// dmem_mmio_pkg
// Shared constants for the data-memory-mapped display/timer peripheral:
//   - register offsets inside the 32-byte window (word index = addr[4:2])
//   - CTRL / STATUS bit positions
//   - window width in address bits
//   - run state of the counter
// -----------------------------------------------------------------------------
package dmem_mmio_pkg;

  // Register window is 2**WIN_BITS bytes (8 words).
  localparam int WIN_BITS = 5;

  localparam logic [2:0] OFF_DISP    = 3'd0;
  localparam logic [2:0] OFF_CTRL    = 3'd1;
  localparam logic [2:0] OFF_COUNT   = 3'd2;
  localparam logic [2:0] OFF_COMPARE = 3'd3;
  localparam logic [2:0] OFF_STATUS  = 3'd4;
  localparam logic [2:0] OFF_CAPTURE = 3'd5;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_AUTO    = 1;
  localparam int CTRL_IRQEN   = 2;
  localparam int STATUS_MATCH = 0;

  // The EN bit of CTRL is the counter's run state.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

endpackage

// File: rtl/dmem_mmio_timer_prescaler.sv
// -----------------------------------------------------------------------------
// mmio_prescaler
// Divides clk by PRESC_DIV to produce a one-cycle tick while enabled.
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-high reset
//   en    in  counting enable; the count is held at 0 while low
//   clr   in  restart the count at 0 on the next edge
//   tick  out high during the last cycle of each PRESC_DIV-cycle period
// -----------------------------------------------------------------------------
module mmio_prescaler #(
  parameter int PRESC_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESC_DIV - 1);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;

  assign tick = en & (presc_q == LAST);

  always_comb begin
    presc_d = presc_q;
    if (clr || !en || (presc_q == LAST)) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/dmem_mmio_timer.sv
// -----------------------------------------------------------------------------
// dmem_mmio_timer
// Responder on the CPU data-memory bus providing a display register for the
// 7-segment scanner and a prescaled up-counter with compare/match/interrupt.
//
// Register window (word offset = addr[4:2], addr[1:0] ignored):
//   0 DISP     R/W
//   1 CTRL     R/W  bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN
//   2 COUNT    R/W
//   3 COMPARE  R/W
//   4 STATUS   bit0 MATCH, write 1 to clear
//   5 CAPTURE  RO, only with DMEM_MMIO_TIMER_CAPTURE_EN (COUNT latched on any
//              DISP write); otherwise reads 0
//   6..7       read 0, writes ignored
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   ena, wena         bus strobe and write enable
//   addr, data_in     byte address and write data
//   data_out          combinational read data (0 unless a hit read)
//   disp_out          current DISP value
//   irq               MATCH & IRQ_EN
//
// Optional feature macro: DMEM_MMIO_TIMER_CAPTURE_EN
// -----------------------------------------------------------------------------
module dmem_mmio_timer
  import dmem_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          PRESC_DIV = 16,
  parameter logic [31:0] DISP_RST  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        wena,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [31:0] disp_out,
  output logic        irq
);

  logic        hit;
  logic        wr;
  logic        rd;
  logic [2:0]  off;
  logic        wr_ctrl;
  logic        wr_count;
  logic        presc_clr;
  logic        run_en;
  logic        tick;
  logic        unused_addr_lsbs;

  run_state_e  state_q,   state_d;
  logic        auto_q,    auto_d;
  logic        irqen_q,   irqen_d;
  logic        match_q,   match_d;
  logic [31:0] disp_q,    disp_d;
  logic [31:0] count_q,   count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] ctrl_rd;

  assign hit              = (addr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
  assign off              = addr[WIN_BITS-1:2];
  assign unused_addr_lsbs = ^addr[1:0];
  assign wr               = ena & wena & hit;
  assign rd               = ena & ~wena & hit;
  assign wr_ctrl          = wr & (off == OFF_CTRL);
  assign wr_count         = wr & (off == OFF_COUNT);
  // A CPU write to CTRL or COUNT restarts the prescaler and swallows any
  // tick landing on the same edge.
  assign presc_clr        = wr_ctrl | wr_count;
  assign run_en           = (state_q == ST_RUN);

  mmio_prescaler #(
    .PRESC_DIV(PRESC_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (run_en),
    .clr  (presc_clr),
    .tick (tick)
  );

  assign disp_out = disp_q;
  assign irq      = match_q & irqen_q;

  always_comb begin
    ctrl_rd             = '0;
    ctrl_rd[CTRL_EN]    = run_en;
    ctrl_rd[CTRL_AUTO]  = auto_q;
    ctrl_rd[CTRL_IRQEN] = irqen_q;
  end

`ifdef DMEM_MMIO_TIMER_CAPTURE_EN
  logic [31:0] capture_q, capture_d;

  always_comb begin
    capture_d = capture_q;
    if (wr && (off == OFF_DISP)) begin
      capture_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      capture_q <= '0;
    end else begin
      capture_q <= capture_d;
    end
  end
`endif

  // Read mux: zero-latency, no side effects.
  always_comb begin
    data_out = '0;
    if (rd) begin
      case (off)
        OFF_DISP:    data_out = disp_q;
        OFF_CTRL:    data_out = ctrl_rd;
        OFF_COUNT:   data_out = count_q;
        OFF_COMPARE: data_out = compare_q;
        OFF_STATUS:  data_out = {31'd0, match_q};
`ifdef DMEM_MMIO_TIMER_CAPTURE_EN
        OFF_CAPTURE: data_out = capture_q;
`endif
        default:     data_out = '0;
      endcase
    end
  end

  // Next state: CPU writes first, then the tick. Ordering the tick last lets a
  // match set override a same-cycle W1C; CTRL/COUNT writes never see a tick.
  always_comb begin
    state_d   = state_q;
    auto_d    = auto_q;
    irqen_d   = irqen_q;
    match_d   = match_q;
    disp_d    = disp_q;
    count_d   = count_q;
    compare_d = compare_q;

    if (wr) begin
      case (off)
        OFF_DISP:    disp_d = data_in;
        OFF_CTRL: begin
          state_d = data_in[CTRL_EN] ? ST_RUN : ST_IDLE;
          auto_d  = data_in[CTRL_AUTO];
          irqen_d = data_in[CTRL_IRQEN];
        end
        OFF_COUNT:   count_d = data_in;
        OFF_COMPARE: compare_d = data_in;
        OFF_STATUS: begin
          if (data_in[STATUS_MATCH]) begin
            match_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (tick && !presc_clr) begin
      if (count_q == compare_q) begin
        match_d = 1'b1;
        if (auto_q) begin
          count_d = '0;
        end else begin
          // One-shot: freeze COUNT at the compare value and stop.
          state_d = ST_IDLE;
        end
      end else begin
        count_d = count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      auto_q    <= 1'b0;
      irqen_q   <= 1'b0;
      match_q   <= 1'b0;
      disp_q    <= DISP_RST;
      count_q   <= '0;
      compare_q <= '0;
    end else begin
      state_q   <= state_d;
      auto_q    <= auto_d;
      irqen_q   <= irqen_d;
      match_q   <= match_d;
      disp_q    <= disp_d;
      count_q   <= count_d;
      compare_q <= compare_d;
    end
  end

endmodule

// File: tb/tb_dmem_mmio_timer.sv
// -----------------------------------------------------------------------------
// tb_dmem_mmio_timer
// Self-checking bench for dmem_mmio_timer (PRESC_DIV=4, nonzero DISP_RST).
// A cycle-level behavioural model tracks the register file; directed tests add
// fixed expected values at the points the timer rules pin down.
// -----------------------------------------------------------------------------
module tb_dmem_mmio_timer;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          PDIV = 4;
  localparam logic [31:0] DRST = 32'hCAFE_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        wena;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [31:0] disp_out;
  logic        irq;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [31:0] m_disp, m_count, m_compare, m_capture;
  bit          m_en, m_auto, m_irqen, m_match;
  int          m_presc;

  dmem_mmio_timer #(
    .BASE_ADDR(BASE),
    .PRESC_DIV(PDIV),
    .DISP_RST (DRST)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .wena    (wena),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .disp_out(disp_out),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_disp = DRST; m_count = 0; m_compare = 0; m_capture = 0;
    m_en = 0; m_auto = 0; m_irqen = 0; m_match = 0; m_presc = 0;
  endfunction

  function automatic logic [31:0] model_read(input int off);
    case (off)
      0: return m_disp;
      1: return {29'd0, m_irqen, m_auto, m_en};
      2: return m_count;
      3: return m_compare;
      4: return {31'd0, m_match};
`ifdef DMEM_MMIO_TIMER_CAPTURE_EN
      5: return m_capture;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of the peripheral, from the bus values present at that edge.
  function automatic void model_step(input logic e, input logic w,
                                     input logic [31:0] a, input logic [31:0] d);
    bit hit, wr, cpu_clr, tick_eff, set_match, w1c, n_en;
    int off;
    logic [31:0] n_count;
    hit       = ((a >> 5) == (BASE >> 5));
    off       = int'((a >> 2) & 32'd7);
    wr        = e && w && hit;
    cpu_clr   = wr && (off == 1 || off == 2);
    tick_eff  = m_en && (m_presc == PDIV - 1) && !cpu_clr;
    set_match = tick_eff && (m_count == m_compare);
    w1c       = wr && (off == 4) && d[0];
    n_count   = m_count;
    n_en      = m_en;
    if (tick_eff) begin
      if (set_match) begin
        if (m_auto) n_count = 0;
        else        n_en = 0;
      end else begin
        n_count = m_count + 32'd1;
      end
    end
    if (!m_en || cpu_clr) m_presc = 0;
    else                  m_presc = (m_presc + 1) % PDIV;
    if (wr && off == 0) begin
      m_disp = d;
`ifdef DMEM_MMIO_TIMER_CAPTURE_EN
      m_capture = m_count;
`endif
    end
    if (wr && off == 1) begin n_en = d[0]; m_auto = d[1]; m_irqen = d[2]; end
    if (wr && off == 2) n_count = d;
    if (wr && off == 3) m_compare = d;
    m_match = set_match ? 1'b1 : (w1c ? 1'b0 : m_match);
    m_count = n_count;
    m_en    = n_en;
  endfunction

  task automatic drive(input bit e, input bit w, input logic [31:0] a, input logic [31:0] d);
    ena = e; wena = w; addr = a; data_in = d;
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_step(ena, wena, addr, data_in);
    #1;
  endtask

  task automatic wr_reg(input int off, input logic [31:0] val);
    drive(1, 1, BASE + 32'(off * 4), val);
    clk_step();
    drive(0, 0, 32'd0, 32'd0);
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    for (int off = 0; off < 8; off++) begin
      drive(1, 0, BASE + 32'(off * 4), 32'd0);
      #1;
      exp = (off == 0) ? DRST : 32'd0;
      total++;
      if (data_out !== exp) begin
        bad++; $display("FAIL reset_read_off%0d: got %h want %h", off, data_out, exp);
      end
      clk_step();
    end
    drive(0, 0, 32'd0, 32'd0);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    total++;
    if (disp_out !== DRST) begin bad++; $display("FAIL reset_disp_out: got %h want %h", disp_out, DRST); end
  endtask

  task automatic test_bus();
    wr_reg(0, 32'h1234_5678);
    total++;
    if (disp_out !== 32'h1234_5678) begin
      bad++; $display("FAIL disp_write: got %h want 12345678", disp_out);
    end
    drive(1, 1, BASE + 32'h20, 32'hFFFF_0000);
    clk_step();
    drive(0, 0, 32'd0, 32'd0);
    total++;
    if (disp_out !== 32'h1234_5678) begin
      bad++; $display("FAIL disp_miss_write: got %h want 12345678", disp_out);
    end
    drive(0, 0, BASE, 32'd0);
    #1;
    total++;
    if (data_out !== 32'd0) begin bad++; $display("FAIL read_no_ena: got %h want 0", data_out); end
    drive(1, 0, BASE + 32'd3, 32'd0);
    #1;
    total++;
    if (data_out !== 32'h1234_5678) begin
      bad++; $display("FAIL read_lsb_ignored: got %h want 12345678", data_out);
    end
    clk_step();
  endtask

  task automatic test_periodic();
    wr_reg(1, 32'd0); wr_reg(4, 32'd1); wr_reg(2, 32'd0); wr_reg(3, 32'd3);
    wr_reg(1, 32'd7);
    for (int k = 1; k <= 16; k++) begin
      drive(1, 0, BASE + 32'd8, 32'd0);
      clk_step();
      total++;
      if (data_out !== model_read(2)) begin
        bad++; $display("FAIL periodic_count_c%0d: got %h want %h", k, data_out, model_read(2));
      end
      if (k == 4 || k == 12) begin
        total++;
        if (data_out !== 32'(k / 4)) begin
          bad++; $display("FAIL periodic_step_c%0d: got %h want %h", k, data_out, 32'(k / 4));
        end
      end
    end
    total++;
    if (data_out !== 32'd0 || irq !== 1'b1) begin
      bad++; $display("FAIL periodic_match: count %h irq %b want count 0 irq 1", data_out, irq);
    end
    wr_reg(4, 32'd1);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL periodic_w1c_irq: got %b want 0", irq); end
  endtask

  task automatic test_one_shot();
    wr_reg(1, 32'd0); wr_reg(4, 32'd1); wr_reg(2, 32'd0); wr_reg(3, 32'd2);
    wr_reg(1, 32'd1);
    for (int k = 1; k <= 20; k++) begin
      drive(1, 0, BASE + 32'd8, 32'd0);
      clk_step();
      total++;
      if (data_out !== model_read(2)) begin
        bad++; $display("FAIL oneshot_count_c%0d: got %h want %h", k, data_out, model_read(2));
      end
    end
    drive(1, 0, BASE + 32'd4, 32'd0); #1;
    total++;
    if (data_out !== 32'd0) begin bad++; $display("FAIL oneshot_ctrl: got %h want 0", data_out); end
    drive(1, 0, BASE + 32'd16, 32'd0); #1;
    total++;
    if (data_out !== 32'd1) begin bad++; $display("FAIL oneshot_status: got %h want 1", data_out); end
    drive(0, 0, 32'd0, 32'd0);
    repeat (8) clk_step();
    drive(1, 0, BASE + 32'd8, 32'd0); #1;
    total++;
    if (data_out !== 32'd2) begin bad++; $display("FAIL oneshot_hold: got %h want 2", data_out); end
    clk_step();
  endtask

  task automatic test_wrap();
    wr_reg(1, 32'd0); wr_reg(2, 32'hFFFF_FFFF); wr_reg(3, 32'd5); wr_reg(1, 32'd1);
    repeat (4) clk_step();
    drive(1, 0, BASE + 32'd8, 32'd0); #1;
    total++;
    if (data_out !== 32'd0) begin bad++; $display("FAIL count_wrap: got %h want 0", data_out); end
    clk_step();
    wr_reg(1, 32'd0);
  endtask

  task automatic test_collisions();
    logic [31:0] anchor;
    wr_reg(1, 32'd0); wr_reg(4, 32'd1); wr_reg(2, 32'd0); wr_reg(3, 32'd0);
    wr_reg(1, 32'd1);
    for (int c = 1; c <= 16; c++) begin
      if (c == 4)       drive(1, 1, BASE + 32'd8, 32'd100);
      else if (c == 11) drive(1, 1, BASE + 32'd8, 32'd200);
      else              drive(0, 0, 32'd0, 32'd0);
      clk_step();
      drive(1, 0, BASE + 32'd8, 32'd0);
      #1;
      total++;
      if (data_out !== model_read(2)) begin
        bad++; $display("FAIL coll_count_c%0d: got %h want %h", c, data_out, model_read(2));
      end
      anchor = 32'hFFFF_FFFF;
      case (c)
        4, 7:   anchor = 32'd100;
        8:      anchor = 32'd101;
        12, 14: anchor = 32'd200;
        15:     anchor = 32'd201;
        default: ;
      endcase
      if (anchor != 32'hFFFF_FFFF) begin
        total++;
        if (data_out !== anchor) begin
          bad++; $display("FAIL coll_anchor_c%0d: got %h want %h", c, data_out, anchor);
        end
      end
    end
    drive(1, 0, BASE + 32'd16, 32'd0); #1;
    total++;
    if (data_out !== 32'd0) begin bad++; $display("FAIL coll_match_discarded: got %h want 0", data_out); end
    drive(1, 0, BASE + 32'd4, 32'd0); #1;
    total++;
    if (data_out !== 32'd1) begin bad++; $display("FAIL coll_still_running: got %h want 1", data_out); end
    clk_step();
    // W1C landing on the match edge: the set wins.
    wr_reg(1, 32'd0); wr_reg(4, 32'd1); wr_reg(2, 32'd0); wr_reg(3, 32'd0);
    wr_reg(1, 32'd3);
    repeat (3) clk_step();
    wr_reg(4, 32'd1);
    drive(1, 0, BASE + 32'd16, 32'd0); #1;
    total++;
    if (data_out !== 32'd1) begin bad++; $display("FAIL coll_w1c_vs_set: got %h want 1", data_out); end
    clk_step();
  endtask

  task automatic test_async_reset();
    wr_reg(1, 32'd0); wr_reg(2, 32'd7); wr_reg(3, 32'd1000);
    wr_reg(0, 32'hDEAD_BEEF); wr_reg(1, 32'd7);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
    drive(1, 0, BASE + 32'd8, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (disp_out !== DRST || irq !== 1'b0 || data_out !== 32'd0) begin
      bad++; $display("FAIL async_reset: disp %h irq %b count %h want %h 0 0",
                      disp_out, irq, data_out, DRST);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 32'd0, 32'd0);
    repeat (10) clk_step();
    drive(1, 0, BASE + 32'd8, 32'd0); #1;
    total++;
    if (data_out !== 32'd0) begin bad++; $display("FAIL reset_no_resume: got %h want 0", data_out); end
    clk_step();
  endtask

  task automatic test_capture();
    logic [31:0] exp;
`ifdef DMEM_MMIO_TIMER_CAPTURE_EN
    exp = 32'd5;
`else
    exp = 32'd0;
`endif
    wr_reg(1, 32'd0); wr_reg(2, 32'd5); wr_reg(0, 32'h0000_00AA);
    drive(1, 0, BASE + 32'd20, 32'd0); #1;
    total++;
    if (data_out !== exp) begin bad++; $display("FAIL capture_read: got %h want %h", data_out, exp); end
    clk_step();
  endtask

  task automatic test_random();
    bit e, w, hit;
    int off;
    logic [31:0] a, d, exp;
    for (int i = 0; i < 400; i++) begin
      off = $urandom_range(0, 7);
      hit = ($urandom_range(0, 7) != 0);
      a   = (hit ? BASE : BASE + 32'h20 * $urandom_range(1, 100)) + 32'(off * 4) + $urandom_range(0, 3);
      e   = ($urandom_range(0, 7) != 0);
      w   = ($urandom_range(0, 2) == 0);
      case (off)
        1:       d = $urandom_range(0, 7);
        2, 3:    d = $urandom_range(0, 6);
        4:       d = $urandom_range(0, 1);
        default: d = $urandom;
      endcase
      drive(e, w, a, d);
      #1;
      exp = (e && !w && hit) ? model_read(off) : 32'd0;
      total++;
      if (data_out !== exp || irq !== (m_match && m_irqen) || disp_out !== m_disp) begin
        bad++;
        $display("FAIL random_%0d: data %h irq %b disp %h want %h %b %h",
                 i, data_out, irq, disp_out, exp, m_match && m_irqen, m_disp);
      end
      clk_step();
    end
    drive(0, 0, 32'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 32'd0, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_bus();
    test_periodic();
    test_one_shot();
    test_wrap();
    test_collisions();
    test_async_reset();
    test_capture();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
